// File: rtl/store_unit.sv
// MEM-stage store path: selects int/FP store data, formats SB/SH/SW into word
// address, replicated data and byte enables, and drains them in order via req/ack.
module store_unit #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [2:0]       st_funct3,
  input  logic [WIDTH-1:0] st_addr,
  input  logic             st_fp_sel,
  input  logic [WIDTH-1:0] int_data,
  input  logic [WIDTH-1:0] fp_data,
  output logic             st_stall,
  output logic             st_misalign,
  output logic             sb_empty,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [3:0]       be;
  } sb_entry_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  sb_entry_t       buf_q [DEPTH];

  logic [WIDTH-1:0] st_data;
  logic [1:0]       ofs;
  logic             legal;
  logic             full;
  logic             push;
  logic             pop;
  sb_entry_t        new_entry;
  sb_entry_t        head;

  assign st_data = st_fp_sel ? fp_data : int_data;
  assign ofs     = st_addr[1:0];

  always_comb begin
    new_entry.addr  = {st_addr[WIDTH-1:2], 2'b00};
    new_entry.wdata = '0;
    new_entry.be    = 4'b0000;
    legal           = 1'b0;
    case (st_funct3)
      3'b000: begin
        new_entry.wdata = {4{st_data[7:0]}};
        new_entry.be    = 4'b0001 << ofs;
        legal           = 1'b1;
      end
      3'b001: begin
        new_entry.wdata = {2{st_data[15:0]}};
        new_entry.be    = 4'b0011 << ofs;
        legal           = ~ofs[0];
      end
      3'b010: begin
        new_entry.wdata = st_data;
        new_entry.be    = 4'b1111;
        legal           = (ofs == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end

  // Full is taken from the registered count so a same-cycle ack never frees a slot.
  assign full        = (count_q == CW'(DEPTH));
  assign st_misalign = st_valid & ~legal;
  assign st_stall    = st_valid & full & ~st_misalign;
  assign push        = st_valid & ~full & ~st_misalign;
  assign pop         = (state_q == BUSY) & mem_ack;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = BUSY;
      BUSY:    if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= new_entry;
  end

  assign head      = buf_q[rd_ptr_q];
  assign mem_req   = (state_q == BUSY);
  assign mem_addr  = mem_req ? head.addr  : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;
  assign mem_be    = mem_req ? head.be    : 4'b0000;
  assign sb_empty  = (count_q == '0) & (state_q == IDLE);

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: table vectors, hand sequences for fill/drain/reset, and
// random traffic checked every cycle against a queue-based reference model.
module tb_store_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic        st_fp_sel;
  logic [31:0] int_data;
  logic [31:0] fp_data;
  logic        st_stall;
  logic        st_misalign;
  logic        sb_empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  always #5 clk = ~clk;

  store_unit #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_funct3(st_funct3),
    .st_addr(st_addr), .st_fp_sel(st_fp_sel), .int_data(int_data),
    .fp_data(fp_data), .st_stall(st_stall), .st_misalign(st_misalign),
    .sb_empty(sb_empty), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  // Reference model: buffered stores in order, plus whether the head is on the bus.
  ent_t q[$];
  bit   busy;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        fp_sel;
    logic [31:0] idata;
    logic [31:0] fdata;
    logic        mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vec[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit mdl_mis();
    int s;
    if (!st_valid) return 0;
    s = size_of(st_funct3);
    if (s == 0) return 1;
    return (st_addr % s) != 0;
  endfunction

  function automatic ent_t mdl_fmt();
    ent_t        e;
    int          s;
    logic [31:0] d;
    logic [3:0]  m;
    s = size_of(st_funct3);
    if (s == 0) s = 4;
    d = st_fp_sel ? fp_data : int_data;
    e.addr = st_addr & ~32'h3;
    m = 4'((1 << s) - 1);
    e.be = m << st_addr[1:0];
    for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = d[8*(b % s) +: 8];
    return e;
  endfunction

  // Compare all outputs against the model, then advance one clock.
  task automatic step();
    bit   e_mis, e_stall, push, was_nonempty;
    ent_t e, h;
    #1;
    e_mis   = mdl_mis();
    e_stall = st_valid && !e_mis && (q.size() == DEPTH);
    h = busy ? q[0] : '{32'h0, 32'h0, 4'h0};
    check("misalign", st_misalign, e_mis);
    check("stall",    st_stall,    e_stall);
    check("sb_empty", sb_empty,    (q.size() == 0) && !busy);
    check("mem_req",  mem_req,     busy);
    check("mem_addr", mem_addr,    h.addr);
    check("mem_wdata", mem_wdata,  h.wdata);
    check("mem_be",   mem_be,      h.be);
    push = st_valid && !e_mis && !e_stall;
    e = mdl_fmt();
    @(posedge clk);
    was_nonempty = (q.size() != 0);
    if (busy && mem_ack) void'(q.pop_front());
    if (push) q.push_back(e);
    busy = busy ? (q.size() != 0) : was_nonempty;
    #1;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    for (int c = 0; c < 20 && (q.size() != 0 || busy); c++) step();
    mem_ack = 1'b0;
    check("drain_done", {31'h0, (q.size() == 0 && !busy)}, 32'h1);
    #1 check("drain_sb_empty", sb_empty, 1'b1);
  endtask

  task automatic set_store(input logic [2:0] f3, input logic [31:0] a, input logic fps,
                           input logic [31:0] id, input logic [31:0] fd);
    st_valid = 1'b1; st_funct3 = f3; st_addr = a;
    st_fp_sel = fps; int_data = id; fp_data = fd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs[$];
    int          gaps;
    bit          fifth_go;

    vec[0] = '{3'b000, 32'h0000_1003, 1'b0, 32'hAABBCCDD, 32'h0,        1'b0, 32'h1000, 32'hDDDDDDDD, 4'b1000};
    vec[1] = '{3'b001, 32'h0000_2002, 1'b1, 32'h0,        32'h12345678, 1'b0, 32'h2000, 32'h56785678, 4'b1100};
    vec[2] = '{3'b010, 32'h0000_0040, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0040, 32'hCAFEF00D, 4'b1111};
    vec[3] = '{3'b000, 32'h0000_0005, 1'b0, 32'h11223344, 32'h0,        1'b0, 32'h0004, 32'h44444444, 4'b0010};
    vec[4] = '{3'b001, 32'h0000_0008, 1'b0, 32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 32'h0008, 32'hBEEFBEEF, 4'b0011};
    vec[5] = '{3'b010, 32'h0000_3001, 1'b0, 32'h1,        32'h0,        1'b1, 32'h0,    32'h0,        4'b0000};
    vec[6] = '{3'b001, 32'h0000_3003, 1'b0, 32'h1,        32'h0,        1'b1, 32'h0,    32'h0,        4'b0000};
    vec[7] = '{3'b011, 32'h0000_3000, 1'b0, 32'h1,        32'h0,        1'b1, 32'h0,    32'h0,        4'b0000};
    vec[8] = '{3'b100, 32'h0000_0000, 1'b0, 32'h1,        32'h0,        1'b1, 32'h0,    32'h0,        4'b0000};

    rst = 1'b1; st_valid = 1'b0; st_funct3 = 3'b000; st_addr = '0;
    st_fp_sel = 1'b0; int_data = '0; fp_data = '0; mem_ack = 1'b0;
    q.delete(); busy = 0;
    #3;
    check("rst_req",   mem_req,  1'b0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_empty", sb_empty, 1'b1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Formatting table, each store held 3 cycles without ack, then drained.
    for (int i = 0; i < 9; i++) begin
      set_store(vec[i].f3, vec[i].addr, vec[i].fp_sel, vec[i].idata, vec[i].fdata);
      mem_ack = 1'b0;
      #1 check("tbl_mis", st_misalign, vec[i].mis);
      check("tbl_nostall", st_stall, 1'b0);
      step();
      st_valid = 1'b0;
      if (!vec[i].mis) begin
        step();
        check("tbl_req",   mem_req,   1'b1);
        check("tbl_addr",  mem_addr,  vec[i].exp_addr);
        check("tbl_wdata", mem_wdata, vec[i].exp_wdata);
        check("tbl_be",    mem_be,    vec[i].exp_be);
        repeat (3) step();
        check("tbl_hold_addr", mem_addr, vec[i].exp_addr);
        check("tbl_hold_be",   mem_be,   vec[i].exp_be);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("tbl_req_drop", mem_req,  1'b0);
        check("tbl_empty",    sb_empty, 1'b1);
      end else begin
        step();
        check("tbl_mis_noreq", mem_req,  1'b0);
        check("tbl_mis_empty", sb_empty, 1'b1);
      end
    end

    // Fill to DEPTH with no ack; only the fifth store stalls.
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(3'b010, 32'h10 + 32'(4*i), 1'b0, 32'hA000_0000 + 32'(i), 32'h0);
      #1 check("fill_stall", st_stall, 1'b0);
      step();
    end
    set_store(3'b010, 32'h20, 1'b0, 32'hA000_0004, 32'h0);
    #1 check("fill_stall5", st_stall, 1'b1);
    mem_ack = 1'b1;
    obs.delete(); gaps = 0;
    for (int c = 0; c < 30 && obs.size() < 5; c++) begin
      #1;
      fifth_go = st_valid && !st_stall;
      if (mem_req) obs.push_back(mem_addr);
      else if (obs.size() > 0) gaps++;
      step();
      if (fifth_go) st_valid = 1'b0;
    end
    mem_ack = 1'b0;
    check("b2b_count", obs.size(), 5);
    check("b2b_gaps", gaps, 0);
    for (int i = 0; i < 5; i++)
      check("b2b_order", (i < obs.size()) ? obs[i] : 32'hFFFF_FFFF, 32'h10 + 32'(4*i));
    drain();

    // Reset mid-cycle with three entries queued and a request on the bus.
    for (int i = 0; i < 3; i++) begin
      set_store(3'b010, 32'h100 + 32'(4*i), 1'b0, 32'h5555_0000 + 32'(i), 32'h0);
      step();
    end
    st_valid = 1'b0;
    step();
    check("pre_rst_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req",   mem_req,   1'b0);
    check("async_rst_addr",  mem_addr,  32'h0);
    check("async_rst_wdata", mem_wdata, 32'h0);
    check("async_rst_be",    mem_be,    4'h0);
    check("async_rst_empty", sb_empty,  1'b1);
    q.delete(); busy = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    set_store(3'b010, 32'h0000_0200, 1'b0, 32'h0BAD_F00D, 32'h0);
    step();
    st_valid = 1'b0;
    step();
    check("post_rst_addr",  mem_addr,  32'h200);
    check("post_rst_wdata", mem_wdata, 32'h0BAD_F00D);
    drain();

    // Random traffic, every cycle checked by the model.
    for (int c = 0; c < 400; c++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      st_addr   = $urandom & 32'h0000_0FFF;
      st_fp_sel = 1'($urandom_range(0, 1));
      int_data  = $urandom;
      fp_data   = $urandom;
      mem_ack   = ($urandom_range(0, 2) == 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
